// File: rtl/pipeline_sequencer_pkg.sv
// Shared pipeline definitions: FSM state encodings, HALT and decode opcodes.
// Used by the pipeline_sequencer top (optional macro PIPE_SEQ_STALL_CNT_EN).
package pipeline_pkg;

  localparam logic [5:0] HALT_OPCODE  = 6'h3f;
  localparam logic [5:0] OPC_BEQ      = 6'h04;
  localparam logic [5:0] OPC_BNE      = 6'h05;
  localparam logic [5:0] OPC_LW       = 6'h23;
  localparam int         DRAIN_CYCLES = 3;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_RUN       = 3'd1,
    ST_STEP_WAIT = 3'd2,
    ST_STEP      = 3'd3,
    ST_DRAIN     = 3'd4,
    ST_HALTED    = 3'd5
  } state_e;

  function automatic logic is_branch_op(input logic [5:0] op);
    return (op == OPC_BEQ) || (op == OPC_BNE);
  endfunction

  function automatic logic is_load_op(input logic [5:0] op);
    return op == OPC_LW;
  endfunction

endpackage

// File: rtl/pipeline_sequencer_if.sv
// Control bundle between the pipeline/debug side (master) and the sequencer (slave).
// o_stall_count exists only when PIPE_SEQ_STALL_CNT_EN is defined.
interface pipeline_sequencer_if #(
  parameter int NB_OPCODE = 6,
  parameter int NB_REG    = 5,
  parameter int NB_CYCLES = 32
);
  logic                 i_start;
  logic                 i_step_mode;
  logic                 i_step;
  logic [NB_OPCODE-1:0] i_id_opcode;
  logic [NB_REG-1:0]    i_id_rs;
  logic [NB_REG-1:0]    i_id_rt;
  logic                 i_ex_mem_read;
  logic [NB_REG-1:0]    i_ex_rt;
  logic                 i_ex_branch_taken;
  logic                 o_stage_en;
  logic                 o_pc_write;
  logic                 o_if_id_write;
  logic                 o_id_ex_bubble;
  logic                 o_if_id_flush;
  logic                 o_id_ex_flush;
  logic                 o_halted;
  logic [2:0]           o_state;
  logic [NB_CYCLES-1:0] o_cycle_count;
`ifdef PIPE_SEQ_STALL_CNT_EN
  logic [NB_CYCLES-1:0] o_stall_count;
`endif

  modport master (
    output i_start, i_step_mode, i_step, i_id_opcode, i_id_rs, i_id_rt,
           i_ex_mem_read, i_ex_rt, i_ex_branch_taken,
    input  o_stage_en, o_pc_write, o_if_id_write, o_id_ex_bubble,
           o_if_id_flush, o_id_ex_flush, o_halted, o_state, o_cycle_count
`ifdef PIPE_SEQ_STALL_CNT_EN
    , input o_stall_count
`endif
  );

  modport slave (
    input  i_start, i_step_mode, i_step, i_id_opcode, i_id_rs, i_id_rt,
           i_ex_mem_read, i_ex_rt, i_ex_branch_taken,
    output o_stage_en, o_pc_write, o_if_id_write, o_id_ex_bubble,
           o_if_id_flush, o_id_ex_flush, o_halted, o_state, o_cycle_count
`ifdef PIPE_SEQ_STALL_CNT_EN
    , output o_stall_count
`endif
  );

endinterface

// File: rtl/pipeline_sequencer_hazard_detect.sv
// Load-use hazard compare: a load in EX whose rt feeds the instruction in ID.
module hazard_detect #(
  parameter int NB_REG = 5
) (
  input  logic              ex_mem_read_i,
  input  logic [NB_REG-1:0] ex_rt_i,
  input  logic [NB_REG-1:0] id_rs_i,
  input  logic [NB_REG-1:0] id_rt_i,
  output logic              stall_o
);

  assign stall_o = ex_mem_read_i && (ex_rt_i != '0) &&
                   ((ex_rt_i == id_rs_i) || (ex_rt_i == id_rt_i));

endmodule

// File: rtl/pipeline_sequencer.sv
// Pipeline controller: run/step sequencing, load-use stall, branch flush, HALT drain.
// Optional stall counter enabled by PIPE_SEQ_STALL_CNT_EN.
module pipeline_sequencer #(
  parameter int                   NB_OPCODE    = 6,
  parameter int                   NB_REG       = 5,
  parameter int                   NB_CYCLES    = 32,
  parameter logic [NB_OPCODE-1:0] HALT_OPCODE  = pipeline_pkg::HALT_OPCODE,
  parameter int                   DRAIN_CYCLES = pipeline_pkg::DRAIN_CYCLES
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  pipeline_sequencer_if.slave   bus
);
  import pipeline_pkg::*;

  localparam int NB_DRAIN = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

  state_e               state_q, state_d;
  logic [NB_DRAIN-1:0]  drain_q, drain_d;
  logic [NB_CYCLES-1:0] cycle_q;
  logic                 stall_s, halt_s, branch_s;
  logic                 stage_en_s, pc_write_s, if_id_write_s, bubble_s;
  logic                 if_id_flush_s, id_ex_flush_s;

  hazard_detect #(.NB_REG(NB_REG)) u_hazard (
    .ex_mem_read_i (bus.i_ex_mem_read),
    .ex_rt_i       (bus.i_ex_rt),
    .id_rs_i       (bus.i_id_rs),
    .id_rt_i       (bus.i_id_rt),
    .stall_o       (stall_s)
  );

  assign branch_s = bus.i_ex_branch_taken;
  // A HALT sharing the cycle with a taken branch is on the squashed path.
  assign halt_s   = (bus.i_id_opcode == HALT_OPCODE) && !branch_s;

  // Next-state and pipeline control outputs.
  always_comb begin
    state_d       = state_q;
    drain_d       = drain_q;
    stage_en_s    = 1'b0;
    pc_write_s    = 1'b0;
    if_id_write_s = 1'b0;
    bubble_s      = 1'b0;
    if_id_flush_s = 1'b0;
    id_ex_flush_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.i_start) begin
          state_d = bus.i_step_mode ? ST_STEP_WAIT : ST_RUN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN, ST_STEP: begin
        stage_en_s    = 1'b1;
        pc_write_s    = branch_s || !stall_s;
        if_id_write_s = branch_s || !stall_s;
        bubble_s      = stall_s && !branch_s;
        if_id_flush_s = branch_s;
        id_ex_flush_s = branch_s;
        if (halt_s) begin
          state_d = ST_DRAIN;
          drain_d = NB_DRAIN'(DRAIN_CYCLES - 1);
        end else begin
          state_d = (state_q == ST_STEP) ? ST_STEP_WAIT : state_q;
        end
      end
      ST_STEP_WAIT: begin
        if (bus.i_step) begin
          state_d = ST_STEP;
        end else begin
          state_d = ST_STEP_WAIT;
        end
      end
      ST_DRAIN: begin
        stage_en_s    = 1'b1;
        bubble_s      = stall_s && !branch_s;
        if_id_flush_s = branch_s;
        id_ex_flush_s = branch_s;
        if (drain_q == '0) begin
          state_d = ST_HALTED;
        end else begin
          drain_d = drain_q - NB_DRAIN'(1);
        end
      end
      ST_HALTED: state_d = ST_HALTED;
      default:   state_d = ST_IDLE;
    endcase
  end

  // State, drain and cycle counter registers.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state_q <= ST_IDLE;
      drain_q <= '0;
      cycle_q <= '0;
    end else begin
      state_q <= state_d;
      drain_q <= drain_d;
      if (stage_en_s) begin
        cycle_q <= cycle_q + NB_CYCLES'(1);
      end
    end
  end

`ifdef PIPE_SEQ_STALL_CNT_EN
  logic [NB_CYCLES-1:0] stall_cnt_q;

  // Count enabled cycles that inserted a load-use bubble.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      stall_cnt_q <= '0;
    end else if (stage_en_s && bubble_s) begin
      stall_cnt_q <= stall_cnt_q + NB_CYCLES'(1);
    end
  end

  assign bus.o_stall_count = stall_cnt_q;
`endif

  assign bus.o_stage_en     = stage_en_s;
  assign bus.o_pc_write     = pc_write_s;
  assign bus.o_if_id_write  = if_id_write_s;
  assign bus.o_id_ex_bubble = bubble_s;
  assign bus.o_if_id_flush  = if_id_flush_s;
  assign bus.o_id_ex_flush  = id_ex_flush_s;
  assign bus.o_halted       = (state_q == ST_HALTED);
  assign bus.o_state        = state_q;
  assign bus.o_cycle_count  = cycle_q;

endmodule
